// File: rtl/circulant_link_pipe_pkg.sv
`default_nettype none
// =============================================================================
// circulant_link_pipe_pkg
// Shared index arithmetic and slice state encoding for the circulant link pipe.
// Revision: 1.0
// =============================================================================

`define ADD_MOD(a, b, n) (((a) + (b)) % (n))
`define SUB_MOD(a, b, n) (((a) + (n) - (b)) % (n))

package circulant_link_pipe_pkg;

    localparam int c_STEP_W = 8;

    localparam logic [1:0] c_SLICE_EMPTY = 2'd0;
    localparam logic [1:0] c_SLICE_ONE   = 2'd1;
    localparam logic [1:0] c_SLICE_TWO   = 2'd2;

    function automatic int port_idx_w(input int ports);
        return (ports > 1) ? $clog2(ports) : 1;
    endfunction

    // Forward ports (p < k) step up the ring, mirrored ports step down.
    function automatic int dst_node(input int i, input int p, input int k,
                                    input int step, input int n);
        if (p < k)
            return `ADD_MOD(i, step, n);
        return `SUB_MOD(i, step, n);
    endfunction

    function automatic int dst_port(input int p, input int k);
        return 2 * k - 1 - p;
    endfunction

endpackage

`default_nettype wire

// File: rtl/circulant_link_pipe_link_slice.sv
`default_nettype none
// =============================================================================
// circulant_link_pipe_link_slice
// Two-entry (main + skid) full-throughput register slice with registered ready.
// Revision: 1.0
// =============================================================================

module circulant_link_pipe_link_slice
    import circulant_link_pipe_pkg::*;
#(
    parameter int FLIT_W = 37
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] flit_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic [FLIT_W-1:0] flit_o,
    output logic              valid_o,
    input  logic              ready_i
);

    logic [1:0]        state_q, state_d;
    logic [FLIT_W-1:0] main_q, main_d;
    logic [FLIT_W-1:0] skid_q, skid_d;
    logic              w_in_beat;
    logic              w_out_beat;

    assign w_in_beat  = valid_i & ready_o;
    assign w_out_beat = valid_o & ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_SLICE_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            c_SLICE_EMPTY: begin
                if (w_in_beat) begin
                    state_d = c_SLICE_ONE;
                    main_d  = flit_i;
                end
            end
            c_SLICE_ONE: begin
                if (w_in_beat && w_out_beat) begin
                    main_d = flit_i;
                end else if (w_in_beat) begin
                    state_d = c_SLICE_TWO;
                    skid_d  = flit_i;
                end else if (w_out_beat) begin
                    state_d = c_SLICE_EMPTY;
                end
            end
            c_SLICE_TWO: begin
                // ready is low in TWO, so only the drain case exists here
                if (w_out_beat) begin
                    state_d = c_SLICE_ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = c_SLICE_EMPTY;
        endcase
    end

    // ready depends only on state (and rst), never on ready_i
    always_comb begin
        ready_o = (state_q != c_SLICE_TWO) & ~rst;
        valid_o = (state_q != c_SLICE_EMPTY);
        flit_o  = main_q;
    end

endmodule

`default_nettype wire

// File: rtl/circulant_link_pipe.sv
`default_nettype none
// =============================================================================
// circulant_link_pipe
// Circulant router interconnect with pipelined, flow-controlled, gateable links.
// Revision: 1.0
// =============================================================================

module circulant_link_pipe
    import circulant_link_pipe_pkg::*;
#(
    parameter int                  NODES_NUM  = 8,
    parameter int                  STEPS      = 2,
    parameter logic [8*STEPS-1:0]  STEP_VEC   = {8'd3, 8'd1},
    parameter int                  FLIT_W     = 37,
    parameter int                  PIPE_DEPTH = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NODES_NUM*2*STEPS*FLIT_W-1:0]  flit_i,
    input  logic [NODES_NUM*2*STEPS-1:0]         valid_i,
    output logic [NODES_NUM*2*STEPS-1:0]         ready_o,
    output logic [NODES_NUM*2*STEPS*FLIT_W-1:0]  flit_o,
    output logic [NODES_NUM*2*STEPS-1:0]         valid_o,
    input  logic [NODES_NUM*2*STEPS-1:0]         ready_i,
    input  logic [NODES_NUM*2*STEPS-1:0]         link_en
);

    localparam int P          = 2 * STEPS;
    localparam int PORT_IDX_W = port_idx_w(P);

    if (STEPS < 1) begin : g_err_steps
        $error("circulant_link_pipe: STEPS must be at least 1");
    end
    if (NODES_NUM < 3) begin : g_err_nodes
        $error("circulant_link_pipe: NODES_NUM must be at least 3");
    end
    if (PIPE_DEPTH < 0 || PIPE_DEPTH > 4) begin : g_err_depth
        $error("circulant_link_pipe: PIPE_DEPTH must be in 0..4");
    end
    for (genvar s = 0; s < STEPS; s++) begin : g_chk_step
        if (STEP_VEC[c_STEP_W*s +: c_STEP_W] == '0 ||
            int'(STEP_VEC[c_STEP_W*s +: c_STEP_W]) >= NODES_NUM) begin : g_err_step
            $error("circulant_link_pipe: step %0d out of range 1..N-1", s);
        end
    end

    for (genvar i = 0; i < NODES_NUM; i++) begin : g_node
        for (genvar p = 0; p < P; p++) begin : g_port
            localparam int SRC      = i * P + p;
            localparam int STEP_SEL = (p < STEPS) ? p : P - 1 - p;
            localparam int STEP     = int'(STEP_VEC[c_STEP_W*STEP_SEL +: c_STEP_W]);
            localparam logic [PORT_IDX_W-1:0] c_DST_PORT = PORT_IDX_W'(dst_port(p, STEPS));
            localparam int DST      = dst_node(i, p, STEPS, STEP, NODES_NUM) * P
                                      + int'(c_DST_PORT);

            if (PIPE_DEPTH == 0) begin : g_wire
                assign valid_o[DST]                  = valid_i[SRC] & link_en[SRC] & ~rst;
                assign flit_o[DST*FLIT_W +: FLIT_W]  = flit_i[SRC*FLIT_W +: FLIT_W];
                assign ready_o[SRC]                  = ready_i[DST] & link_en[SRC] & ~rst;
            end else begin : g_pipe
                logic [FLIT_W-1:0] w_flit  [PIPE_DEPTH+1];
                logic              w_valid [PIPE_DEPTH+1];
                logic              w_ready [PIPE_DEPTH+1];

                // Disabling a link only closes its entry; flits already inside drain.
                assign w_flit[0]                     = flit_i[SRC*FLIT_W +: FLIT_W];
                assign w_valid[0]                    = valid_i[SRC] & link_en[SRC];
                assign ready_o[SRC]                  = w_ready[0] & link_en[SRC];
                assign flit_o[DST*FLIT_W +: FLIT_W]  = w_flit[PIPE_DEPTH];
                assign valid_o[DST]                  = w_valid[PIPE_DEPTH];
                assign w_ready[PIPE_DEPTH]           = ready_i[DST];

                for (genvar d = 0; d < PIPE_DEPTH; d++) begin : g_slice
                    circulant_link_pipe_link_slice #(
                        .FLIT_W (FLIT_W)
                    ) u_slice (
                        .clk     (clk),
                        .rst     (rst),
                        .flit_i  (w_flit[d]),
                        .valid_i (w_valid[d]),
                        .ready_o (w_ready[d]),
                        .flit_o  (w_flit[d+1]),
                        .valid_o (w_valid[d+1]),
                        .ready_i (w_ready[d+1])
                    );
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_circulant_link_pipe.sv
`default_nettype none
// =============================================================================
// tb_circulant_link_pipe
// Self-checking bench: three depth variants sharing stimulus, scoreboard on depth 2.
// Revision: 1.0
// =============================================================================

module tb_circulant_link_pipe;

    localparam int N  = 8;
    localparam int K  = 2;
    localparam int P  = 4;
    localparam int NP = N * P;
    localparam int FW = 37;

    typedef struct {
        int sn;
        int sp;
        int dn;
        int dp;
    } conn_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NP*FW-1:0]  flit_i;
    logic [NP-1:0]     valid_i, ready_i, link_en;
    logic [NP-1:0]     ready_o1, valid_o1, ready_o2, valid_o2, ready_o3, valid_o3;
    logic [NP*FW-1:0]  flit_o1, flit_o2, flit_o3;

    int checks = 0;
    int errors = 0;
    logic [FW-1:0] sbq [NP][$];

    always #5 clk = ~clk;

    circulant_link_pipe #(.NODES_NUM(N), .STEPS(K), .STEP_VEC(16'h0301), .FLIT_W(FW), .PIPE_DEPTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .flit_i(flit_i), .valid_i(valid_i), .ready_o(ready_o1),
        .flit_o(flit_o1), .valid_o(valid_o1), .ready_i(ready_i), .link_en(link_en));
    circulant_link_pipe #(.NODES_NUM(N), .STEPS(K), .STEP_VEC(16'h0301), .FLIT_W(FW), .PIPE_DEPTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .flit_i(flit_i), .valid_i(valid_i), .ready_o(ready_o2),
        .flit_o(flit_o2), .valid_o(valid_o2), .ready_i(ready_i), .link_en(link_en));
    circulant_link_pipe #(.NODES_NUM(N), .STEPS(K), .STEP_VEC(16'h0301), .FLIT_W(FW), .PIPE_DEPTH(3)) u_dut3 (
        .clk(clk), .rst(rst), .flit_i(flit_i), .valid_i(valid_i), .ready_o(ready_o3),
        .flit_o(flit_o3), .valid_o(valid_o3), .ready_i(ready_i), .link_en(link_en));

    function automatic int step_of(input int s);
        return (s == 0) ? 1 : 3;
    endfunction

    function automatic int dst_idx(input int src);
        int n, p;
        n = src / P;
        p = src % P;
        if (p < K)
            return ((n + step_of(p)) % N) * P + (P - 1 - p);
        return ((n + N - step_of(P - 1 - p)) % N) * P + (P - 1 - p);
    endfunction

    function automatic logic [FW-1:0] code(input int n, input int p);
        return {21'h1ABCD, n[7:0], p[7:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference FIFO per destination link of the depth-2 instance.
    task automatic sb_update();
        if (rst) begin
            for (int d = 0; d < NP; d++) sbq[d].delete();
            return;
        end
        for (int s = 0; s < NP; s++)
            if (valid_i[s] && ready_o2[s]) sbq[dst_idx(s)].push_back(flit_i[s*FW +: FW]);
        for (int d = 0; d < NP; d++) begin
            if (valid_o2[d] && ready_i[d]) begin
                if (sbq[d].size() == 0)
                    check($sformatf("sb_unexpected_beat_link%0d", d), 64'd1, 64'd0);
                else
                    check($sformatf("sb_data_link%0d", d), 64'(flit_o2[d*FW +: FW]), 64'(sbq[d].pop_front()));
            end
        end
    endtask

    task automatic next_cycle();
        sb_update();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            valid_i = '0;
            #1;
            next_cycle();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        conn_t tbl [4];
        int    acc, got, nextf, d;
        logic  exp_v;

        tbl[0] = '{6, 0, 7, 3};
        tbl[1] = '{1, 1, 4, 2};
        tbl[2] = '{0, 2, 5, 1};
        tbl[3] = '{0, 3, 7, 0};

        flit_i  = '0;
        valid_i = '0;
        ready_i = '1;
        link_en = '1;
        rst     = 1'b1;
        repeat (3) @(negedge clk);

        // ---- reset state ----
        #1;
        check("rst_valid_o1", 64'(valid_o1), 64'd0);
        check("rst_flit_o1_zero", 64'(flit_o1 != '0), 64'd0);
        check("rst_ready_o1", 64'(ready_o1), 64'd0);
        check("rst_valid_o3", 64'(valid_o3), 64'd0);
        next_cycle();
        rst = 1'b0;
        #1;
        check("post_rst_ready_o1", 64'(ready_o1), 64'hFFFF_FFFF);
        check("post_rst_ready_o2", 64'(ready_o2), 64'hFFFF_FFFF);
        next_cycle();

        // ---- connectivity, depth 1 ----
        for (int s = 0; s < NP; s++) flit_i[s*FW +: FW] = code(s / P, s % P);
        valid_i = '1;
        #1;
        check("conn_pre_valid", 64'(valid_o1), 64'd0);
        next_cycle();
        valid_i = '0;
        #1;
        for (int s = 0; s < NP; s++) begin
            d = dst_idx(s);
            check($sformatf("conn_valid_src%0d", s), 64'(valid_o1[d]), 64'd1);
            check($sformatf("conn_flit_src%0d", s), 64'(flit_o1[d*FW +: FW]), 64'(code(s / P, s % P)));
        end
        for (int t = 0; t < 4; t++) begin
            d = tbl[t].dn * P + tbl[t].dp;
            check($sformatf("conn_tbl%0d_valid", t), 64'(valid_o1[d]), 64'd1);
            check($sformatf("conn_tbl%0d_flit", t), 64'(flit_o1[d*FW +: FW]), 64'(code(tbl[t].sn, tbl[t].sp)));
        end
        next_cycle();
        #1;
        check("conn_post_valid", 64'(valid_o1), 64'd0);
        next_cycle();
        idle(8);

        // ---- throughput, depth 3: node 0 port 0 -> node 1 port 3 ----
        for (int c = 0; c < 106; c++) begin
            valid_i = '0;
            if (c < 100) begin
                valid_i[0]     = 1'b1;
                flit_i[0 +: FW] = FW'(c);
            end
            #1;
            if (c < 100) check($sformatf("tput_ready_c%0d", c), 64'(ready_o3[0]), 64'd1);
            exp_v = (c >= 3) && (c < 103);
            check($sformatf("tput_valid_c%0d", c), 64'(valid_o3[7]), 64'(exp_v));
            if (exp_v) check($sformatf("tput_flit_c%0d", c), 64'(flit_o3[7*FW +: FW]), 64'(c - 3));
            next_cycle();
        end
        idle(8);

        // ---- backpressure, depth 2 ----
        ready_i[7] = 1'b0;
        acc   = 0;
        nextf = 200;
        for (int c = 0; c < 8; c++) begin
            valid_i         = '0;
            valid_i[0]      = 1'b1;
            flit_i[0 +: FW] = FW'(nextf);
            #1;
            if (ready_o2[0]) begin
                acc++;
                nextf++;
            end
            if (c >= 2) begin
                check($sformatf("bp_stall_valid_c%0d", c), 64'(valid_o2[7]), 64'd1);
                check($sformatf("bp_stall_flit_c%0d", c), 64'(flit_o2[7*FW +: FW]), 64'd200);
            end
            if (c == 7) check("bp_ready_low", 64'(ready_o2[0]), 64'd0);
            next_cycle();
        end
        check("bp_accepted", 64'(acc), 64'd4);
        valid_i    = '0;
        ready_i[7] = 1'b1;
        got = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (valid_o2[7]) begin
                check($sformatf("bp_release_flit%0d", got), 64'(flit_o2[7*FW +: FW]), 64'(200 + got));
                got++;
            end
            next_cycle();
        end
        check("bp_released_count", 64'(got), 64'd4);
        idle(4);

        // ---- reset mid-operation with slices in TWO ----
        ready_i = '0;
        for (int c = 0; c < 6; c++) begin
            valid_i = '1;
            for (int s = 0; s < NP; s++) flit_i[s*FW +: FW] = FW'({$urandom(), $urandom()});
            #1;
            next_cycle();
        end
        #1;
        check("mid_full_ready_low", 64'(ready_o2), 64'd0);
        next_cycle();
        valid_i = '0;
        rst     = 1'b1;
        #1;
        check("mid_rst_ready_low", 64'(ready_o2), 64'd0);
        next_cycle();
        rst     = 1'b0;
        ready_i = '1;
        #1;
        check("mid_post_valid_o2", 64'(valid_o2), 64'd0);
        check("mid_post_valid_o3", 64'(valid_o3), 64'd0);
        check("mid_post_ready_o2", 64'(ready_o2), 64'hFFFF_FFFF);
        check("mid_post_flit_zero", 64'(flit_o2 != '0), 64'd0);
        next_cycle();
        for (int c = 0; c < 6; c++) begin
            #1;
            check($sformatf("mid_no_stale_c%0d", c), 64'(valid_o2), 64'd0);
            next_cycle();
        end

        // ---- link disable with two flits buffered ----
        ready_i[7] = 1'b0;
        for (int c = 0; c < 2; c++) begin
            valid_i         = '0;
            valid_i[0]      = 1'b1;
            flit_i[0 +: FW] = FW'(300 + c);
            #1;
            check($sformatf("dis_fill_ready%0d", c), 64'(ready_o2[0]), 64'd1);
            next_cycle();
        end
        link_en[0]      = 1'b0;
        flit_i[0 +: FW] = FW'(999);
        #1;
        check("dis_ready_immediate", 64'(ready_o2[0]), 64'd0);
        next_cycle();
        ready_i[7] = 1'b1;
        got = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            check($sformatf("dis_ready_c%0d", c), 64'(ready_o2[0]), 64'd0);
            if (valid_o2[7]) begin
                check($sformatf("dis_drain_flit%0d", got), 64'(flit_o2[7*FW +: FW]), 64'(300 + got));
                got++;
            end
            next_cycle();
        end
        check("dis_drained_count", 64'(got), 64'd2);
        link_en[0]      = 1'b1;
        flit_i[0 +: FW] = FW'(302);
        #1;
        check("dis_reenable_ready", 64'(ready_o2[0]), 64'd1);
        next_cycle();
        valid_i = '0;
        got = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (valid_o2[7]) begin
                check("dis_reenable_flit", 64'(flit_o2[7*FW +: FW]), 64'd302);
                got++;
            end
            next_cycle();
        end
        check("dis_reenable_count", 64'(got), 64'd1);

        // ---- random traffic against the reference FIFOs ----
        for (int c = 0; c < 10000; c++) begin
            for (int s = 0; s < NP; s++) begin
                valid_i[s]       = 1'($urandom_range(0, 1));
                ready_i[s]       = 1'($urandom_range(0, 1));
                link_en[s]       = ($urandom_range(0, 9) != 0);
                flit_i[s*FW +: FW] = FW'({$urandom(), $urandom()});
            end
            #1;
            for (int s = 0; s < NP; s++)
                if (!link_en[s]) check($sformatf("rnd_dis_ready_s%0d", s), 64'(ready_o2[s]), 64'd0);
            next_cycle();
        end
        valid_i = '0;
        ready_i = '1;
        link_en = '1;
        idle(12);
        for (int k = 0; k < NP; k++)
            check($sformatf("rnd_drained_link%0d", k), 64'(sbq[k].size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
